seg_scan_decoder: RTL and testbench
===================================

# seg_scan_decoder

Time-multiplexed digit-scan driver for the stopwatch 7-segment display, and the parametrised successor of the fixed 2-to-4 select decoder. It owns the refresh prescaler and digit index, and drives a one-hot digit-enable vector of configurable width and polarity. Each slot starts with an anti-ghosting blank window, and per-digit masking is supported. It sits between the stopwatch counters and the segment mux: `o_sel` picks the BCD nibble and `o_an` drives the display commons.

## Interface
- `N_DIGITS`, default 4: number of digits, 2..16.
- `SEL_W`, default `$clog2(N_DIGITS)`: select width (derived, do not override).
- `REFRESH_DIV`, default 50000: clock cycles per digit slot, >= 2.
- `BLANK_CYCLES`, default 16: leading cycles of each slot with all digits off; 0..REFRESH_DIV-1.
- `ACTIVE_LOW`, default 1: 1 means `o_an` bits are active-low (common-anode board).
- `i_clk` in 1: system clock, rising edge.
- `i_rst_n` in 1: asynchronous active-low reset.
- `i_en` in 1: scan enable.
- `i_digit_mask` in N_DIGITS: 1 = digit displayed; bit k corresponds to index k.
- `o_sel` out SEL_W: current digit index, for the segment-data mux.
- `o_an` out N_DIGITS: one-hot digit enable, polarity set by ACTIVE_LOW.
- `o_tick` out 1: one-cycle pulse on each slot start.

## Operation
- All outputs are registered.
- Reset values:
  - state IDLE, prescaler 0, index 0.
  - `o_sel` = 0, `o_tick` = 0.
  - `o_an` all inactive: all 1s if ACTIVE_LOW, else all 0s.
- States:
  - IDLE: anodes inactive, prescaler held at 0, index held.
  - BLANK: anodes inactive, prescaler counting.
  - ON: `o_an[o_sel]` active only if `i_digit_mask[o_sel]`; all other bits inactive.
- Transitions:
  - IDLE -> BLANK when `i_en`=1. Start a fresh slot at the current index and pulse `o_tick`.
  - BLANK -> ON when prescaler = BLANK_CYCLES-1. If BLANK_CYCLES=0, a slot enters ON directly and BLANK is never visited.
  - ON -> BLANK (or -> ON if BLANK_CYCLES=0) when prescaler = REFRESH_DIV-1. Prescaler returns to 0, the index advances, and `o_tick` pulses.
  - any -> IDLE when `i_en`=0, effective next cycle. Index is held, so the scan resumes at the same digit with a full new slot.
- Index advance: increments and wraps N_DIGITS-1 -> 0, correct for non-power-of-2 N.
- Mask changes take effect on `o_an` the following cycle. Slot timing is not disturbed.
- Invariant: at most one `o_an` bit is active in any cycle.

## Timing
- Slot length is exactly REFRESH_DIV cycles. Full frame is N_DIGITS × REFRESH_DIV cycles (without skipping).
- `o_tick` and the new `o_sel` value appear in the same cycle.
- `o_an` goes active exactly BLANK_CYCLES cycles after that cycle.
- Latency from `i_en` rising to first `o_tick`: 1 cycle.
- Latency from `i_en` falling to all anodes inactive: 1 cycle.
- Reset asserted mid-slot forces reset values immediately, with no clock required.

## Configuration
- `SCAN_SKIP_MASKED_EN` defined:
  - Index advance jumps to the next index (mod N_DIGITS) whose mask bit is 1, so masked digits consume no slot. Frame length becomes popcount(mask) × REFRESH_DIV.
  - If only the current digit is enabled, the index stays.
  - If the mask is all 0, the index stays, anodes stay inactive, and `o_tick` keeps pulsing every REFRESH_DIV cycles.
- Macro undefined: plain increment. Masked digits still occupy their slot with anodes inactive (constant frame length).

## Test plan
All scenarios use N_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2, ACTIVE_LOW=1.
- Reset then `i_en`=1, mask 4'b1111:
  - `o_sel` sequence is 0,1,2,3,0 with `o_tick` every 8 cycles.
  - `o_an` = 4'b1111 for 2 cycles, then 4'b1110 for 6 cycles at `o_sel`=0, then 4'b1101 at `o_sel`=1, and so on.
- Mask 4'b0101, macro undefined:
  - 32-cycle frame; `o_an` stays 4'b1111 throughout the slots for indices 1 and 3.
- Mask 4'b0101, macro defined:
  - `o_sel` alternates 0,2,0,2; frame is 16 cycles.
  - Mask 4'b0000: `o_sel` frozen, `o_an` = 4'b1111, `o_tick` still every 8 cycles.
- `i_en` dropped at prescaler 5 of the `o_sel`=2 slot:
  - Next cycle `o_an` = 4'b1111.
  - On re-enable, `o_tick` fires after 1 cycle with `o_sel`=2, and the slot lasts a full 8 cycles.
- `i_rst_n` pulsed low mid-ON, without a clock edge:
  - `o_an` = 4'b1111, `o_sel` = 0, `o_tick` = 0 immediately.
- BLANK_CYCLES=0 and ACTIVE_LOW=0, N_DIGITS=3:
  - `o_sel` wraps 2 -> 0.
  - `o_an` is 3'b001 -> 3'b010 -> 3'b100 with no idle gap.
  - All cycles satisfy the one-hot assertion.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: time-multiplexed 7-segment digit-scan driver (prescaler, index, blanking, per-digit mask).
// Latency: all outputs registered; i_en rise -> first o_tick 1 cycle, i_en fall -> anodes off 1 cycle.
// Backpressure: none, free-running scan paced by REFRESH_DIV; define SCAN_SKIP_MASKED_EN to skip masked digits.

module seg_scan_decoder #(
  parameter int N_DIGITS     = 4,
  parameter int SEL_W        = $clog2(N_DIGITS),  // derived from N_DIGITS, leave at default
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_en,
  input  logic [N_DIGITS-1:0] i_digit_mask,
  output logic [SEL_W-1:0]    o_sel,
  output logic [N_DIGITS-1:0] o_an,
  output logic                o_tick
);

  localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PRE_W-1:0]    PRE_LAST   = PRE_W'(REFRESH_DIV - 1);
  localparam logic [PRE_W-1:0]    BLANK_LAST = (BLANK_CYCLES > 0) ? PRE_W'(BLANK_CYCLES - 1) : '0;
  localparam logic [SEL_W-1:0]    IDX_LAST   = SEL_W'(N_DIGITS - 1);
  // Inactive anode level for the whole vector, set by board polarity
  localparam logic [N_DIGITS-1:0] AN_OFF     = (ACTIVE_LOW != 0) ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_BLANK,
    S_ON
  } state_t;

  state_t              r_state;
  logic [PRE_W-1:0]    r_presc;
  logic [SEL_W-1:0]    r_idx;
  logic [N_DIGITS-1:0] r_an;
  logic                r_tick;

  logic [SEL_W-1:0]    w_idx_inc;
  logic [SEL_W-1:0]    w_idx_adv;
  logic [N_DIGITS-1:0] w_an_cur;
  logic [N_DIGITS-1:0] w_an_adv;

  // Plain wrapping increment; explicit compare keeps non-power-of-2 digit counts correct
  always_comb begin
    w_idx_inc = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
  end

`ifdef SCAN_SKIP_MASKED_EN
  logic [SEL_W-1:0] w_cand;
  logic             w_found;

  // Search forward (wrapping) for the next displayed digit; the last candidate is the current
  // index itself, so a single enabled digit or an all-zero mask leaves the index where it is
  always_comb begin
    w_idx_adv = r_idx;
    w_cand    = w_idx_inc;
    w_found   = 1'b0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (!w_found && i_digit_mask[w_cand]) begin
        w_idx_adv = w_cand;
        w_found   = 1'b1;
      end
      w_cand = (w_cand == IDX_LAST) ? '0 : w_cand + 1'b1;
    end
  end
`else
  // Every digit owns a slot, masked or not, so the frame length never changes
  always_comb begin
    w_idx_adv = w_idx_inc;
  end
`endif

  // Anode patterns for the current index and for the index the next slot will use;
  // a digit lights only when selected and its mask bit is set, which keeps the vector one-hot
  always_comb begin
    w_an_cur = AN_OFF;
    w_an_adv = AN_OFF;
    for (int k = 0; k < N_DIGITS; k++) begin
      if ((r_idx == SEL_W'(k)) && i_digit_mask[k]) begin
        w_an_cur[k] = ~AN_OFF[k];
      end
      if ((w_idx_adv == SEL_W'(k)) && i_digit_mask[k]) begin
        w_an_adv[k] = ~AN_OFF[k];
      end
    end
  end

  // Scan FSM: slot = BLANK_CYCLES dark cycles then lit until the prescaler reaches REFRESH_DIV-1;
  // outputs are loaded with the value they must show in the cycle after each edge
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_presc <= '0;
      r_idx   <= '0;
      r_an    <= AN_OFF;
      r_tick  <= 1'b0;
    end else if (!i_en) begin
      // Index is kept so a re-enable resumes on the same digit with a full fresh slot
      r_state <= S_IDLE;
      r_presc <= '0;
      r_an    <= AN_OFF;
      r_tick  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_presc <= '0;
          r_tick  <= 1'b1;
          if (BLANK_CYCLES == 0) begin
            r_state <= S_ON;
            r_an    <= w_an_cur;
          end else begin
            r_state <= S_BLANK;
            r_an    <= AN_OFF;
          end
        end
        S_BLANK: begin
          r_tick  <= 1'b0;
          r_presc <= r_presc + 1'b1;
          if (r_presc == BLANK_LAST) begin
            r_state <= S_ON;
            r_an    <= w_an_cur;
          end else begin
            r_an    <= AN_OFF;
          end
        end
        S_ON: begin
          if (r_presc == PRE_LAST) begin
            r_presc <= '0;
            r_idx   <= w_idx_adv;
            r_tick  <= 1'b1;
            if (BLANK_CYCLES == 0) begin
              r_state <= S_ON;
              r_an    <= w_an_adv;
            end else begin
              r_state <= S_BLANK;
              r_an    <= AN_OFF;
            end
          end else begin
            r_presc <= r_presc + 1'b1;
            r_tick  <= 1'b0;
            r_an    <= w_an_cur;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_presc <= '0;
          r_an    <= AN_OFF;
          r_tick  <= 1'b0;
        end
      endcase
    end
  end

  assign o_sel  = r_idx;
  assign o_an   = r_an;
  assign o_tick = r_tick;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: directed checks of seg_scan_decoder in two configurations.
// Instance A: 4 digits, 8-cycle slots, 2 blank cycles, active-low. Instance B: 3 digits, no blank, active-high.
// Expectations follow SCAN_SKIP_MASKED_EN when the macro is defined for the build.

module tb_seg_scan_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en_a;
  logic       en_b;
  logic [3:0] mask_a;
  logic [2:0] mask_b;
  logic [1:0] sel_a;
  logic [1:0] sel_b;
  logic [3:0] an_a;
  logic [2:0] an_b;
  logic       tick_a;
  logic       tick_b;

  int total   = 0;
  int bad     = 0;
  int oh_viol = 0;

  always #5 clk = ~clk;

  seg_scan_decoder #(
    .N_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2), .ACTIVE_LOW(1)
  ) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en_a), .i_digit_mask(mask_a),
    .o_sel(sel_a), .o_an(an_a), .o_tick(tick_a)
  );

  seg_scan_decoder #(
    .N_DIGITS(3), .REFRESH_DIV(8), .BLANK_CYCLES(0), .ACTIVE_LOW(0)
  ) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en_b), .i_digit_mask(mask_b),
    .o_sel(sel_b), .o_an(an_b), .o_tick(tick_b)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en_a  = 1'b0;
    en_b  = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic start_a(input logic [3:0] mask);
    do_reset();
    mask_a = mask;
    en_a   = 1'b1;
  endtask

  // seq holds the expected o_sel of slot s in bits [2s+1:2s]; first cycle checked is a slot start
  task automatic run_a(input int ncyc, input logic [9:0] seq, input logic [3:0] mask);
    int         s;
    int         p;
    logic [1:0] es;
    logic [3:0] oh;
    logic [3:0] ea;
    for (int c = 0; c < ncyc; c++) begin
      step();
      s  = c / 8;
      p  = c % 8;
      es = seq[2*s +: 2];
      oh = 4'b0001 << es;
      ea = (p < 2 || !mask[es]) ? 4'hF : ~oh;
      chk("tick_a", 16'(tick_a), 16'(p == 0));
      chk("sel_a", 16'(sel_a), 16'(es));
      chk("an_a", 16'(an_a), 16'(ea));
    end
  endtask

  // Neither display may ever light two digits at once
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if ($countones(~an_a) > 1) oh_viol++;
      if ($countones(an_b) > 1) oh_viol++;
    end
  end

  initial begin
    logic [2:0] eb;
    rst_n  = 1'b1;
    en_a   = 1'b0;
    en_b   = 1'b0;
    mask_a = 4'hF;
    mask_b = 3'b111;

    // Reset values appear with no clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("rst_an_a", 16'(an_a), 16'h000F);
    chk("rst_sel_a", 16'(sel_a), 16'h0000);
    chk("rst_tick_a", 16'(tick_a), 16'h0000);
    chk("rst_an_b", 16'(an_b), 16'h0000);
    chk("rst_sel_b", 16'(sel_b), 16'h0000);

    // All digits shown: sel 0,1,2,3,0, tick every 8, 2 dark then 6 lit
    start_a(4'hF);
    run_a(40, 10'h0E4, 4'hF);

    // Mask 0101
    start_a(4'b0101);
`ifdef SCAN_SKIP_MASKED_EN
    run_a(40, 10'h088, 4'b0101);
`else
    run_a(40, 10'h0E4, 4'b0101);
`endif

    // Mask all zero: ticks continue, display dark
    start_a(4'b0000);
`ifdef SCAN_SKIP_MASKED_EN
    run_a(32, 10'h000, 4'b0000);
`else
    run_a(32, 10'h0E4, 4'b0000);
`endif

    // Enable dropped at prescaler 5 of the sel=2 slot, then resumed
    start_a(4'hF);
    run_a(22, 10'h0E4, 4'hF);
    en_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("idle_an_a", 16'(an_a), 16'h000F);
      chk("idle_sel_a", 16'(sel_a), 16'h0002);
      chk("idle_tick_a", 16'(tick_a), 16'h0000);
    end
    en_a = 1'b1;
    run_a(16, 10'h00E, 4'hF);

    // Asynchronous reset in the middle of a lit slot
    start_a(4'hF);
    run_a(28, 10'h0E4, 4'hF);
    chk("pre_rst_an_a", 16'(an_a), 16'h0007);
    #2 rst_n = 1'b0;
    #1;
    chk("async_an_a", 16'(an_a), 16'h000F);
    chk("async_sel_a", 16'(sel_a), 16'h0000);
    chk("async_tick_a", 16'(tick_a), 16'h0000);
    en_a = 1'b0;
    step();
    rst_n = 1'b1;

    // Three digits, no blanking, active-high: wraps 2 -> 0 with no dark gap
    do_reset();
    en_b = 1'b1;
    for (int c = 0; c < 32; c++) begin
      step();
      eb = 3'b001 << ((c / 8) % 3);
      chk("tick_b", 16'(tick_b), 16'((c % 8) == 0));
      chk("sel_b", 16'(sel_b), 16'((c / 8) % 3));
      chk("an_b", 16'(an_b), 16'(eb));
    end
    en_b = 1'b0;
    step();
    chk("off_an_b", 16'(an_b), 16'h0000);

    chk("onehot", 16'(oh_viol), 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
